// File: rtl/alu_ctrl.sv
// Three-state sequencer (IDLE -> ISSUE -> WB) that feeds register-file operands to the
// external registered alu and writes Obus back to the destination register.
package alu_ctrl_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;
endpackage

module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          ck,
  input  logic          res,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [15:0]   inst,
  output logic          done,
  output logic          busy,
  output logic [DW-1:0] alu_l,
  output logic [DW-1:0] alu_r,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_o,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [15:0]   retired
);

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rs1_q, rs1_d;
  logic [AW-1:0] rs2_q, rs2_d;
  logic [15:0]   retired_q, retired_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Address-field bits above AW are don't-care; fold them into one sink.
  logic unused_inst;
  assign unused_inst = ^inst;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    retired_d  = retired_q;
    regs_d     = regs_q;
    inst_ready = 1'b0;
    done       = 1'b0;
    alu_op     = OP_NOP;
    alu_l      = '0;
    alu_r      = '0;

    if (ld_en) begin
      regs_d[ld_addr] = ld_data;
    end

    unique case (state_q)
      IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          op_d    = inst[15:12];
          rd_d    = inst[8 +: AW];
          rs1_d   = inst[4 +: AW];
          rs2_d   = inst[0 +: AW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_op  = op_q;
        alu_l   = regs_q[rs1_q];
        alu_r   = regs_q[rs2_q];
        state_d = WB;
      end
      WB: begin
        done      = 1'b1;
        retired_d = retired_q + 16'd1;
        // Written after the host load so a same-register collision resolves to writeback.
        if (op_q != OP_NOP) begin
          regs_d[rd_q] = alu_o;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ck) begin
    if (res) begin
      state_q   <= IDLE;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      retired_q <= '0;
      // NOTE: the register file is architecturally cleared on reset, so it is built from flops.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign rd_data = regs_q[rd_addr];
  assign retired = retired_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural registered alu on the alu_* ports.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          ck = 1'b0;
  logic          res;
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   inst;
  logic          done;
  logic          busy;
  logic [DW-1:0] alu_l;
  logic [DW-1:0] alu_r;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_o;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [15:0]   retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ck = ~ck;

  alu_ctrl #(.DW(DW), .NREG(8), .AW(AW)) dut (
    .ck(ck), .res(res),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .done(done), .busy(busy),
    .alu_l(alu_l), .alu_r(alu_r), .alu_op(alu_op), .alu_o(alu_o),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .retired(retired)
  );

  // Registered alu: Obus follows OP/Lbus/Rbus by one clock; unknown ops give a marker value.
  always @(posedge ck) begin
    case (alu_op)
      OP_NOP:  alu_o <= '0;
      OP_ADD:  alu_o <= alu_l + alu_r;
      OP_SUB:  alu_o <= alu_l - alu_r;
      OP_AND:  alu_o <= alu_l & alu_r;
      OP_OR:   alu_o <= alu_l | alu_r;
      OP_XOR:  alu_o <= alu_l ^ alu_r;
      default: alu_o <= 16'hA5A5;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] addr, input logic [15:0] exp);
    rd_addr = addr;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // One instruction from IDLE through to the first cycle after done, with an optional host load in WB.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [15:0] exp_l, input logic [15:0] exp_r, input logic [15:0] exp_wb,
                        input logic wb_ld, input logic [AW-1:0] wb_ld_addr,
                        input logic [DW-1:0] wb_ld_data);
    inst       = {op, 1'b0, rd, 1'b0, rs1, 1'b0, rs2};
    inst_valid = 1'b1;
    check({tag, " ready_idle"}, 16'(inst_ready), 16'd1);
    tick();
    inst_valid = 1'b0;
    check({tag, " busy_issue"}, 16'(busy), 16'd1);
    check({tag, " ready_issue"}, 16'(inst_ready), 16'd0);
    check({tag, " alu_op"}, 16'(alu_op), 16'(op));
    check({tag, " alu_l"}, alu_l, exp_l);
    check({tag, " alu_r"}, alu_r, exp_r);
    check({tag, " done_issue"}, 16'(done), 16'd0);
    tick();
    check({tag, " done_wb"}, 16'(done), 16'd1);
    check({tag, " ready_wb"}, 16'(inst_ready), 16'd0);
    if (wb_ld) begin
      ld_en   = 1'b1;
      ld_addr = wb_ld_addr;
      ld_data = wb_ld_data;
    end
    tick();
    ld_en = 1'b0;
    check({tag, " done_after"}, 16'(done), 16'd0);
    check({tag, " ready_after"}, 16'(inst_ready), 16'd1);
    check({tag, " alu_op_idle"}, 16'(alu_op), 16'(OP_NOP));
    read_chk({tag, " writeback"}, rd, exp_wb);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with load and instruction traffic that must both be ignored.
    res        = 1'b1;
    inst_valid = 1'b1;
    inst       = {OP_ADD, 4'd3, 4'd1, 4'd2};
    ld_en      = 1'b1;
    ld_addr    = 3'd1;
    ld_data    = 16'hABCD;
    rd_addr    = '0;
    tick();
    tick();
    tick();
    res        = 1'b0;
    ld_en      = 1'b0;
    inst_valid = 1'b0;
    check("rst inst_ready", 16'(inst_ready), 16'd1);
    check("rst busy", 16'(busy), 16'd0);
    check("rst done", 16'(done), 16'd0);
    check("rst alu_op", 16'(alu_op), 16'(OP_NOP));
    check("rst alu_l", alu_l, 16'h0000);
    check("rst alu_r", alu_r, 16'h0000);
    check("rst retired", retired, 16'd0);
    read_chk("rst R1 load ignored", 3'd1, 16'h0000);

    load(3'd1, 16'h0006);
    load(3'd2, 16'h0003);
    run_op("add", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0006, 16'h0003, 16'h0009, 1'b0, '0, '0);
    check("retired after add", retired, 16'd1);

    run_op("sub", OP_SUB, 3'd4, 3'd1, 3'd2, 16'h0006, 16'h0003, 16'h0003, 1'b0, '0, '0);
    run_op("and", OP_AND, 3'd5, 3'd1, 3'd2, 16'h0006, 16'h0003, 16'h0002, 1'b0, '0, '0);
    run_op("or",  OP_OR,  3'd6, 3'd1, 3'd2, 16'h0006, 16'h0003, 16'h0007, 1'b0, '0, '0);
    run_op("xor", OP_XOR, 3'd7, 3'd1, 3'd2, 16'h0006, 16'h0003, 16'h0005, 1'b0, '0, '0);
    check("retired after logic ops", retired, 16'd5);

    load(3'd2, 16'hFFFD);
    run_op("add wrap", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0006, 16'hFFFD, 16'h0003, 1'b0, '0, '0);

    // inst_valid held high while the word changes: B must wait for the IDLE cycle after done.
    inst       = {OP_SUB, 4'd4, 4'd1, 4'd2};
    inst_valid = 1'b1;
    check("hold A ready", 16'(inst_ready), 16'd1);
    tick();
    inst = {OP_XOR, 4'd5, 4'd1, 4'd2};
    check("hold A ready c1", 16'(inst_ready), 16'd0);
    check("hold A op latched", 16'(alu_op), 16'(OP_SUB));
    tick();
    check("hold A done c2", 16'(done), 16'd1);
    check("hold A ready c2", 16'(inst_ready), 16'd0);
    tick();
    check("hold done c3", 16'(done), 16'd0);
    check("hold ready c3", 16'(inst_ready), 16'd1);
    read_chk("hold A result R4", 3'd4, 16'h0009);
    tick();
    inst_valid = 1'b0;
    check("hold B op", 16'(alu_op), 16'(OP_XOR));
    check("hold B ready c4", 16'(inst_ready), 16'd0);
    tick();
    check("hold B done c5", 16'(done), 16'd1);
    tick();
    check("hold B done c6", 16'(done), 16'd0);
    read_chk("hold B result R5", 3'd5, 16'hFFFB);
    check("retired after hold", retired, 16'd8);

    run_op("nop", OP_NOP, 3'd1, 3'd2, 3'd2, 16'hFFFD, 16'hFFFD, 16'h0006, 1'b0, '0, '0);
    run_op("wb beats load", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0006, 16'hFFFD, 16'h0003,
           1'b1, 3'd3, 16'h1234);
    run_op("wb plus load", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0006, 16'hFFFD, 16'h0003,
           1'b1, 3'd5, 16'h1234);
    read_chk("load beside wb R5", 3'd5, 16'h1234);
    run_op("unknown op", 4'hF, 3'd6, 3'd1, 3'd2, 16'h0006, 16'hFFFD, 16'hA5A5, 1'b0, '0, '0);
    check("retired before reset", retired, 16'd12);

    // Reset during ISSUE discards the instruction.
    inst       = {OP_ADD, 4'd3, 4'd1, 4'd2};
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    check("midrst issue op", 16'(alu_op), 16'(OP_ADD));
    res = 1'b1;
    tick();
    res = 1'b0;
    check("midrst no done", 16'(done), 16'd0);
    tick();
    check("midrst done after", 16'(done), 16'd0);
    check("midrst ready", 16'(inst_ready), 16'd1);
    check("midrst busy", 16'(busy), 16'd0);
    check("midrst retired", retired, 16'd0);
    read_chk("midrst R3", 3'd3, 16'h0000);
    read_chk("midrst R1", 3'd1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Multi-cycle sequencer in front of the codebase's 16-bit alu block. It accepts register-to-register instruction words over a valid/ready handshake and reads both operands from an internal register file. It drives Lbus/Rbus/OP into the alu, captures Obus and writes the result back to the destination register. A host load port and an asynchronous read port give the bench and the future CPU top access to the register file.

Parameters:
DW, 16, datapath width; matches alu Lbus/Rbus/Obus
NREG, 8, number of registers in file (2..16)
AW, 3, register address width, log2(NREG)

Ports:
ck  input  1  clock; all state updates on rising edge
res  input  1  reset, synchronous, active-high
inst_valid  input  1  instruction word present
inst_ready  output  1  controller can accept instruction this cycle
inst  input  16  [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; low AW bits of each address field used
done  output  1  one-cycle pulse: instruction retired
busy  output  1  high whenever state != IDLE
alu_l  output  DW  to alu Lbus
alu_r  output  DW  to alu Rbus
alu_op  output  4  to alu OP (`OP_* codes from define.v)
alu_o  input  DW  from alu Obus
ld_en  input  1  host register write strobe
ld_addr  input  AW  host write address
ld_data  input  DW  host write data
rd_addr  input  AW  host read address
rd_data  output  DW  R[rd_addr], combinational
retired  output  16  count of retired instructions, wraps at FFFF->0000

Behaviour:
- alu contract: alu registers its result on rising ck; Obus is valid the cycle after OP/Lbus/Rbus are presented.
- FSM states: IDLE, ISSUE, WB.
- IDLE: inst_ready=1. On inst_valid, latch inst into internal instruction register and go to ISSUE.
- ISSUE: alu_l=R[rs1], alu_r=R[rs2], alu_op=latched op. Go to WB.
- WB: alu_o valid. If op != `OP_NOP, write R[rd]=alu_o at end of cycle. done=1, retired+=1, go to IDLE.
- Latency: accept edge at cycle 0, done high in cycle 2, result readable via rd_data in cycle 3. Throughput: 1 instruction per 3 cycles.
- inst_ready=0 in ISSUE and WB. inst_valid in those states is ignored, not queued; the requester must hold inst until a cycle with inst_valid&inst_ready.
- Outside ISSUE: alu_op=`OP_NOP, alu_l=alu_r=0.
- Operands are sampled from the file in ISSUE. A load landing in the accept cycle is seen; a load in ISSUE is seen only if it landed at an earlier edge.
- rs1==rs2 is allowed; rd may equal rs1/rs2 (old value used, new value written in WB).
- Arithmetic wraps mod 2^DW; no carry/overflow output (alu Obus is DW bits).
- Unrecognised op codes are passed to the alu unchanged and written back like any non-NOP op.
- ld_en is accepted in any state. If it targets the same register as a WB write in the same cycle, WB wins and the load is dropped. Otherwise both writes occur.
- Reset (any state, including mid-instruction):
  - state=IDLE, all registers=0, retired=0
  - done=0, busy=0, inst_ready=1 from the first cycle after res is released
  - alu_op=`OP_NOP, alu_l=alu_r=0
  - in-flight instruction discarded, no writeback
- While res=1: inst and ld_en are ignored.

Test Plan:
- Reset then loads R1=0006, R2=0003; ADD rd=3 rs1=1 rs2=2 -> alu_l=0006, alu_r=0003, alu_op=`OP_ADD in cycle 1; done pulse in cycle 2; rd_data(3)=0009 in cycle 3; retired=1.
- SUB R4=R1-R2, AND R5, OR R6, XOR R7 on the same operands -> R4=0003, R5=0002, R6=0007, R7=0005; retired=5.
- R2=FFFD; ADD R3=R1+R2 -> R3=0003 (wrap, no carry out).
- inst_valid held high with two different words -> second word accepted only at the first IDLE cycle after done; inst_ready=0 for exactly 2 cycles per instruction; done spaced 3 cycles apart.
- NOP with rd=1 -> done pulses, R1 stays 0006; ld_en to R3=1234 in the same WB cycle as ADD writing R3 -> R3=ADD result; ld_en to R5 in the same cycle -> R5=1234.
- res asserted during ISSUE of ADD R3 -> no done, R3=0000, retired=0, inst_ready=1 the cycle after release.
